vehicle_sensor: RTL and testbench
=================================

VEHICLE_SENSOR -- requirements
Module: vehicle_sensor

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500, is the number of consecutive clk cycles an input must disagree with its filtered value before that value changes (valid range 1..65535).
REQ-002 Parameter STUCK_CYCLES, default 600000, is the number of consecutive clk cycles a filtered input may stay high before it is flagged stuck (valid range 1..2^24-1).
REQ-003 Port: clk  input  1  system clock, nominally 5 kHz, rising-edge active.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Ports: raw_NN, raw_NS, raw_TH  input  1 each  asynchronous loop-detector levels, where 1 means a vehicle is present.
REQ-006 Ports: ack_NN, ack_NS, ack_TH  input  1 each  single-cycle "phase served" pulses from the general fsm.
REQ-007 Ports: SNN, SNS, STH  output  1 each  latched service requests to the general fsm.
REQ-008 Ports: cnt_NN, cnt_NS, cnt_TH  output  4 each  number of pending arrivals per channel.
REQ-009 Ports: fault_NN, fault_NS, fault_TH  output  1 each  stuck-sensor flags.

Function
REQ-010 The three channels SHALL be identical and independent; every rule below applies per channel.
REQ-011 The raw input SHALL pass through a 2-flop synchronizer (s1 -> s2) before any other logic uses it.
REQ-012 The debounce SHALL use a 16-bit counter with these rules:
- if s2 equals the filtered value deb, the counter clears to 0;
- otherwise the counter increments;
- on the cycle the counter equals DEBOUNCE_CYCLES-1, deb takes the value of s2 and the counter clears.
REQ-013 A raw input edge that is stable thereafter SHALL reach deb exactly 2+DEBOUNCE_CYCLES cycles after the first clk edge that samples it.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES cycles, as seen at s2, SHALL leave deb unchanged.
REQ-015 An arrival SHALL be defined as a one-cycle 0->1 transition of deb, detected against a registered copy of deb.
REQ-016 The 4-bit arrival counter cnt SHALL:
- increment by 1 on each arrival;
- saturate at 15, so further arrivals are ignored;
- clear to 0 on ack.
REQ-017 When an ack and an arrival occur in the same cycle, cnt SHALL become 1, because the new arrival survives.
REQ-018 An ack received while cnt=0 SHALL have no effect.
REQ-019 The S* output SHALL be registered and equal (cnt!=0), with one cycle of latency from cnt.
REQ-020 The outputs SHALL NOT interact across channels, including when all three acks and arrivals coincide.
REQ-021 Latency from a raw rising edge to an S* rise SHALL be 2+DEBOUNCE_CYCLES+2 cycles.

Reset
REQ-022 On reset assertion, with no clock required, every register SHALL clear: s1, s2, deb, the debounce counter, cnt, S*, fault_* and the stuck counter.
REQ-023 A raw input that is already high when reset releases SHALL be treated as a new arrival once it is debounced.
REQ-024 Asserting reset mid-debounce or with pending requests SHALL discard that state; no request survives reset.

Configuration
REQ-025 Macro STUCK_DETECT_EN SHALL compile the stuck-sensor detection feature in or out.
REQ-026 With STUCK_DETECT_EN defined, the stuck detection SHALL behave as follows:
- a per-channel 24-bit counter counts consecutive cycles with deb=1 and clears when deb=0;
- when the count reaches STUCK_CYCLES, fault_* sets;
- while fault_* is set, S* is forced to 1 regardless of cnt (fail-safe: the phase keeps being served);
- fault_* clears on the cycle after deb returns to 0;
- ack still clears cnt while faulted.
REQ-027 With STUCK_DETECT_EN undefined:
- fault_* SHALL be tied 0;
- no stuck counter SHALL exist;
- S* SHALL depend only on cnt.

Verification
All scenarios use DEBOUNCE_CYCLES=4 and STUCK_CYCLES=20.
REQ-028 Scenario 1: raw_TH held high from cycle 10 -> deb_TH rises at cycle 16, cnt_TH=1 at cycle 17, STH=1 at cycle 18; SNN=SNS=0 throughout.
REQ-029 Scenario 2: raw_NN pulsed high for 3 cycles -> deb, cnt_NN and SNN stay 0.
REQ-030 Scenario 3: three clean raw_NS pulses of 10 cycles each, separated by 10-cycle gaps, followed by an ack_NS pulse -> cnt_NS counts 1, 2, 3, then becomes 0 one cycle after the ack, and SNS falls one cycle after that.
REQ-031 Scenario 4: an ack_TH pulse in the same cycle as a deb_TH arrival while cnt_TH=2 -> cnt_TH=1 and STH stays 1; 20 arrivals with no ack -> cnt_TH saturates at 15.
REQ-032 Scenario 5: reset asserted mid-cycle while cnt_NN=5 and the debounce is in progress -> all outputs read 0 before the next clk edge; raw_NN still high after release -> SNN=1 at cycle 8 after release.
REQ-033 Scenario 6, with STUCK_DETECT_EN defined: raw_NN held high, then one ack_NN -> fault_NN=1 once the stuck count reaches 20 and SNN remains 1 after the ack; raw_NN released -> fault_NN=0 after 2+4+1 cycles.
REQ-034 Scenario 6, with STUCK_DETECT_EN undefined: same stimulus -> fault_NN stays 0 and SNN falls after the ack.

Source files
------------

// File: rtl/vehicle_sensor.sv
// Three independent loop-detector channels: synchronize, debounce, count arrivals, raise service requests.
// Optional stuck-sensor detection is compiled in with `define STUCK_DETECT_EN.
module vehicle_sensor #(
  parameter int DEBOUNCE_CYCLES = 500,
  parameter int STUCK_CYCLES    = 600000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_NN,
  input  logic       raw_NS,
  input  logic       raw_TH,
  input  logic       ack_NN,
  input  logic       ack_NS,
  input  logic       ack_TH,
  output logic       SNN,
  output logic       SNS,
  output logic       STH,
  output logic [3:0] cnt_NN,
  output logic [3:0] cnt_NS,
  output logic [3:0] cnt_TH,
  output logic       fault_NN,
  output logic       fault_NS,
  output logic       fault_TH
);

  localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] STUCK_LIM = 24'(STUCK_CYCLES);

  logic [2:0] raw;
  logic [2:0] ack;
  logic [2:0] req_all;
  logic [2:0] fault_all;
  logic [3:0] cnt_all [3];

  assign raw = {raw_TH, raw_NS, raw_NN};
  assign ack = {ack_TH, ack_NS, ack_NN};

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    logic        s1_q, s2_q;
    logic        deb_q, deb_d;
    logic        deb_prev_q;
    logic [15:0] dcnt_q, dcnt_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        arrival;
    logic        fault;

    // deb only moves after s2 has disagreed with it for DEBOUNCE_CYCLES straight cycles
    always_comb begin
      deb_d  = deb_q;
      dcnt_d = '0;
      if (s2_q != deb_q) begin
        if (dcnt_q == DEB_LAST) deb_d = s2_q;
        else dcnt_d = dcnt_q + 16'd1;
      end
    end

    assign arrival = deb_q & ~deb_prev_q;

    // A same-cycle arrival survives the ack, so the count restarts at 1
    always_comb begin
      cnt_d = cnt_q;
      if (ack[ch]) cnt_d = arrival ? 4'd1 : 4'd0;
      else if (arrival && cnt_q != 4'd15) cnt_d = cnt_q + 4'd1;
    end

    assign req_d = (cnt_q != 4'd0) | fault;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_q       <= 1'b0;
        s2_q       <= 1'b0;
        deb_q      <= 1'b0;
        deb_prev_q <= 1'b0;
        dcnt_q     <= '0;
        cnt_q      <= '0;
        req_q      <= 1'b0;
      end else begin
        s1_q       <= raw[ch];
        s2_q       <= s1_q;
        deb_q      <= deb_d;
        deb_prev_q <= deb_q;
        dcnt_q     <= dcnt_d;
        cnt_q      <= cnt_d;
        req_q      <= req_d;
      end
    end

`ifdef STUCK_DETECT_EN
    logic [23:0] stuck_q, stuck_d;
    logic        fault_q, fault_d;

    // Counter saturates at the limit so a long-stuck input never wraps and drops the fault
    always_comb begin
      stuck_d = '0;
      if (deb_q) stuck_d = (stuck_q == STUCK_LIM) ? stuck_q : stuck_q + 24'd1;
      fault_d = deb_q & (fault_q | (stuck_d == STUCK_LIM));
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stuck_q <= '0;
        fault_q <= 1'b0;
      end else begin
        stuck_q <= stuck_d;
        fault_q <= fault_d;
      end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign cnt_all[ch]   = cnt_q;
    assign req_all[ch]   = req_q;
    assign fault_all[ch] = fault;
  end

  assign SNN      = req_all[0];
  assign SNS      = req_all[1];
  assign STH      = req_all[2];
  assign cnt_NN   = cnt_all[0];
  assign cnt_NS   = cnt_all[1];
  assign cnt_TH   = cnt_all[2];
  assign fault_NN = fault_all[0];
  assign fault_NS = fault_all[1];
  assign fault_TH = fault_all[2];

endmodule

// File: tb/tb_vehicle_sensor.sv
// Directed bench for vehicle_sensor: each expected output change is queued as {cycle, output vector};
// a monitor pops an entry whenever the observed outputs change and checks both value and cycle.
module tb_vehicle_sensor;

  localparam int W = 50;   // {32-bit cycle, 18-bit output vector}

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       raw_NN = 1'b0, raw_NS = 1'b0, raw_TH = 1'b0;
  logic       ack_NN = 1'b0, ack_NS = 1'b0, ack_TH = 1'b0;
  logic       SNN, SNS, STH;
  logic [3:0] cnt_NN, cnt_NS, cnt_TH;
  logic       fault_NN, fault_NS, fault_TH;

  vehicle_sensor #(.DEBOUNCE_CYCLES(4), .STUCK_CYCLES(20)) dut (
    .clk(clk), .reset(reset),
    .raw_NN(raw_NN), .raw_NS(raw_NS), .raw_TH(raw_TH),
    .ack_NN(ack_NN), .ack_NS(ack_NS), .ack_TH(ack_TH),
    .SNN(SNN), .SNS(SNS), .STH(STH),
    .cnt_NN(cnt_NN), .cnt_NS(cnt_NS), .cnt_TH(cnt_TH),
    .fault_NN(fault_NN), .fault_NS(fault_NS), .fault_TH(fault_TH)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [17:0]  ev = '0;   // expected output vector as it will stand after the latest queued change
  int n_checks = 0;
  int n_fail   = 0;

  wire [17:0] dut_vec = {fault_TH, fault_NS, fault_NN, STH, SNS, SNN, cnt_TH, cnt_NS, cnt_NN};

  task automatic exp_push(input int c);
    logic [W-1:0] e;
    logic [31:0]  cv;
    cv = c;
    e  = {cv, ev};
    if (exp_q.size() > 0 && exp_q[exp_q.size()-1][W-1:18] == cv) exp_q[exp_q.size()-1] = e;
    else exp_q.push_back(e);
  endtask

  task automatic exp_cnt(input int ch, input int v, input int c);
    ev[ch*4 +: 4] = 4'(v);
    exp_push(c);
  endtask

  task automatic exp_s(input int ch, input logic v, input int c);
    ev[12+ch] = v;
    exp_push(c);
  endtask

  task automatic exp_fault(input int ch, input logic v, input int c);
    ev[15+ch] = v;
    exp_push(c);
  endtask

  // ---------------- monitor ----------------
  logic [17:0] prev_vec;
  logic        mon_init = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [31:0]  cv;
    cv = cyc;
    if (!mon_init) begin
      n_checks++;
      if (dut_vec !== 18'd0) begin
        n_fail++;
        $display("FAIL reset_state cyc=%0d got=%h exp=%h", cyc, dut_vec, 18'd0);
      end
      prev_vec = dut_vec;
      mon_init = 1'b1;
    end else if (dut_vec !== prev_vec) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change cyc=%0d got=%h exp=%h (no change expected)", cyc, dut_vec, prev_vec);
      end else begin
        e = exp_q.pop_front();
        if (e[W-1:18] != cv || e[17:0] !== dut_vec) begin
          n_fail++;
          $display("FAIL out_change cyc=%0d got=%h exp=%h at cyc=%0d", cyc, dut_vec, e[17:0], e[W-1:18]);
        end
      end
      prev_vec = dut_vec;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic set_raw(input int ch, input logic v);
    case (ch)
      0: raw_NN = v;
      1: raw_NS = v;
      default: raw_TH = v;
    endcase
  endtask

  task automatic set_ack(input int ch, input logic v);
    case (ch)
      0: ack_NN = v;
      1: ack_NS = v;
      default: ack_TH = v;
    endcase
  endtask

  task automatic pulse_raw(input int ch, input int t, input int len);
    goto(t);
    set_raw(ch, 1'b1);
    goto(t + len);
    set_raw(ch, 1'b0);
  endtask

  task automatic pulse_ack(input int ch, input int t);
    goto(t);
    set_ack(ch, 1'b1);
    goto(t + 1);
    set_ack(ch, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int m;
    goto(2);
    reset = 1'b0;

    // S1: raw_TH rises in cycle 10 -> cnt at 17, STH at 18
    exp_cnt(2, 1, 17);
    exp_s(2, 1'b1, 18);
    goto(10);
    raw_TH = 1'b1;
    goto(24);
    raw_TH = 1'b0;

    // S2: 3-cycle glitch on raw_NN is filtered out
    pulse_raw(0, 40, 3);

    // S3: three NS arrivals, then ack; then an ack with nothing pending
    for (int i = 0; i < 3; i++) begin
      exp_cnt(1, i + 1, 60 + 20*i + 7);
      if (i == 0) exp_s(1, 1'b1, 68);
      pulse_raw(1, 60 + 20*i, 10);
    end
    exp_cnt(1, 0, 121);
    exp_s(1, 1'b0, 122);
    pulse_ack(1, 120);
    pulse_ack(1, 130);

    // S4: second TH arrival, then ack coinciding with the third arrival, then saturation
    exp_cnt(2, 2, 147);
    pulse_raw(2, 140, 10);
    exp_cnt(2, 1, 167);
    goto(160);
    raw_TH = 1'b1;
    pulse_ack(2, 166);
    goto(170);
    raw_TH = 1'b0;
    m = 1;
    for (int i = 0; i < 20; i++) begin
      if (m < 15) begin
        m++;
        exp_cnt(2, m, 180 + 20*i + 7);
      end
      pulse_raw(2, 180 + 20*i, 10);
    end

    // S5: five NN arrivals, then reset mid-debounce with requests pending
    for (int i = 0; i < 5; i++) begin
      exp_cnt(0, i + 1, 600 + 20*i + 7);
      if (i == 0) exp_s(0, 1'b1, 608);
      pulse_raw(0, 600 + 20*i, 10);
    end
    goto(700);
    raw_NN = 1'b1;
    goto(703);
    @(posedge clk);
    #2;
    ev = '0;
    exp_push(cyc);
    reset = 1'b1;
    goto(706);
    reset = 1'b0;
    exp_cnt(0, 1, 713);
    exp_s(0, 1'b1, 714);

    // S6: raw_NN stays high, ack, then release
`ifdef STUCK_DETECT_EN
    exp_fault(0, 1'b1, 732);
    exp_cnt(0, 0, 741);
    exp_fault(0, 1'b0, 757);
    exp_s(0, 1'b0, 758);
`else
    exp_cnt(0, 0, 741);
    exp_s(0, 1'b0, 742);
`endif
    pulse_ack(0, 740);
    goto(750);
    raw_NN = 1'b0;

    goto(800);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_expectations got=%0d left exp=0 next_cyc=%0d", exp_q.size(), exp_q[0][W-1:18]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
